// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Takes one quotient bit per cycle. Divide-by-zero and signed overflow complete in a single cycle.
module div_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_DATA_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [DATA_WIDTH-1:0]     ALUop1,
  input  logic [DATA_WIDTH-1:0]     regOp2,
  input  logic [REG_DATA_WIDTH-1:0] rd_in,
  input  logic                      flush,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_WIDTH-1:0]     result,
  output logic [REG_DATA_WIDTH-1:0] rd_out
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q;
  logic [W-1:0]              rem_q, quo_q, dvs_q;
  logic [1:0]                op_q;
  logic                      sa_q, sb_q;
  logic [REG_DATA_WIDTH-1:0] rd_q;

  // funct3[2] only distinguishes MUL from DIV upstream
  logic unused_f3;
  assign unused_f3 = funct3[2];

  logic          is_signed, sa, sb, div_zero, ovf, special;
  logic [W-1:0]  a_mag, b_mag, sp_res;
  assign is_signed = ~funct3[0];
  assign sa        = is_signed & ALUop1[W-1];
  assign sb        = is_signed & regOp2[W-1];
  assign a_mag     = sa ? -ALUop1 : ALUop1;
  assign b_mag     = sb ? -regOp2 : regOp2;
  assign div_zero  = (regOp2 == '0);
  assign ovf       = is_signed && (ALUop1 == {1'b1, {(W-1){1'b0}}}) && (regOp2 == '1);
  assign special   = div_zero | ovf;

  always_comb begin
    sp_res = '0;
    if (div_zero) sp_res = funct3[1] ? ALUop1 : '1;
    else if (ovf) sp_res = funct3[1] ? '0 : {1'b1, {(W-1){1'b0}}};
  end

  // Remainder stays below the divisor, so the shifted value fits in W+1 bits.
  logic [W:0]   rem_sh, diff;
  logic [W-1:0] rem_nx, quo_nx, q_fix, r_fix;
  always_comb begin
    rem_sh = {rem_q, quo_q[W-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!diff[W]) begin
      rem_nx = diff[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b1};
    end else begin
      rem_nx = rem_sh[W-1:0];
      quo_nx = {quo_q[W-2:0], 1'b0};
    end
    q_fix = (sa_q ^ sb_q) ? -quo_q : quo_q;
    r_fix = sa_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && !flush && !special) state_d = RUN;
      RUN:     if (flush) state_d = IDLE;
               else if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      rd_q   <= '0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start && !flush) begin
          op_q  <= funct3[1:0];
          rd_q  <= rd_in;
          sa_q  <= sa;
          sb_q  <= sb;
          rem_q <= '0;
          quo_q <= a_mag;
          dvs_q <= b_mag;
          cnt_q <= CNT_W'(DATA_WIDTH);
          if (special) begin
            result <= sp_res;
            rd_out <= rd_in;
            done   <= 1'b1;
          end
        end
        RUN: if (!flush) begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        FIX: if (!flush) begin
          result <= op_q[1] ? r_fix : q_fix;
          rd_out <= rd_q;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: normal path, special cases, flush, reset and back-to-back starts.
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] ALUop1, regOp2, result;
  logic [4:0]  rd_in, rd_out;
  logic        busy, done;

  int n_vec = 0;
  int n_err = 0;
  int idx, bcnt;

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .ALUop1(ALUop1),
    .regOp2(regOp2), .rd_in(rd_in), .flush(flush), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a start so that the next posedge is E0; returns #1 after E0.
  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
    @(negedge clk);
    start = 1'b1; funct3 = f; ALUop1 = a; regOp2 = b; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // idx = edges after E0 at which the result was registered; bcnt = busy cycles seen.
  task automatic wait_done();
    idx = 0; bcnt = 0;
    while (!done && idx < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      idx++;
    end
  endtask

  task automatic run(input string tag, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                     input int exp_idx, input int exp_busy);
    start_op(f, a, b, rd);
    wait_done();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, 32'(rd_out), 32'(rd));
    chk({tag, "_lat"}, 32'(idx), 32'(exp_idx));
    chk({tag, "_busy"}, 32'(bcnt), 32'(exp_busy));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    ALUop1 = '0; regOp2 = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    rst = 1'b0;

    run("div100_7", F_DIV, 32'd100, 32'd7, 5'd5, 32'd14, 33, 33);
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("hold_res", result, 32'd14);
    run("rem100_7", F_REM, 32'd100, 32'd7, 5'd5, 32'd2, 33, 33);
    run("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 33, 33);
    run("rem_m7_2", F_REM, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 33, 33);
    run("divu_m7_2", F_DIVU, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'h7FFF_FFFC, 33, 33);
    run("div_by0", F_DIV, 32'd123, 32'd0, 5'd4, 32'hFFFF_FFFF, 0, 0);
    run("remu_by0", F_REMU, 32'd123, 32'd0, 5'd6, 32'd123, 0, 0);
    run("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 0, 0);
    run("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'd0, 0, 0);
    run("divu_ovf", F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'd0, 33, 33);

    // flush on the 10th busy cycle
    start_op(F_DIV, 32'd50, 32'd3, 5'd10);
    repeat (9) @(posedge clk);
    #1;
    chk("fl_busy10", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy0", 32'(busy), 32'd0);
    bcnt = 0;
    repeat (40) begin
      if (done || busy) bcnt++;
      @(posedge clk); #1;
    end
    chk("fl_nodone", 32'(bcnt), 32'd0);
    chk("fl_res_hold", result, 32'd0);
    run("divu_max_1", F_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd11, 32'hFFFF_FFFF, 33, 33);

    // flush coincident with a special-case start
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = F_DIV; ALUop1 = 32'd9; regOp2 = 32'd0; rd_in = 5'd12;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("fl_sp_done", 32'(done), 32'd0);
    chk("fl_sp_busy", 32'(busy), 32'd0);

    // second start mid-op is ignored
    start_op(F_DIV, 32'd1000, 32'd10, 5'd13);
    repeat (5) @(posedge clk);
    @(negedge clk);
    start = 1'b1; funct3 = F_DIV; ALUop1 = 32'd5; regOp2 = 32'd1; rd_in = 5'd14;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("b2b_res", result, 32'd100);
    chk("b2b_rd", 32'(rd_out), 32'd13);
    chk("b2b_lat", 32'(idx), 32'd27);

    // start issued in the done cycle
    chk("dc_done", 32'(done), 32'd1);
    run("dc_remu", F_REMU, 32'd1000, 32'd7, 5'd15, 32'd6, 33, 33);

    // reset mid-op
    start_op(F_DIVU, 32'd77, 32'd7, 5'd16);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_res", result, 32'd0);
    chk("mr_rd", 32'(rd_out), 32'd0);
    run("post_rst", F_DIVU, 32'd77, 32'd7, 5'd17, 32'd11, 33, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
